// File: rtl/data_memory_arbiter_if.sv
// Requester-side bus of the data memory arbiter.
// The requester holds req, we, adr and wdata steady until gnt is seen.
// The arbiter answers with a combinational gnt and returns read data one
// cycle later on rvalid/rdata.
//   req    : access pending
//   we     : 1 = write, 0 = read
//   adr    : access address
//   wdata  : write data
//   gnt    : access accepted this cycle
//   rvalid : read data valid (one-cycle pulse)
//   rdata  : registered read data
interface data_memory_arbiter_if #(
    parameter int DW = 64,
    parameter int AW = 10
);
    logic          req;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, adr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, adr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter/sequencer in front of a data memory with separate
// read and write ports and a combinational read.
// Each cycle it grants at most one read and one write.  The favoured
// requester (prio) alternates whenever it is served.  A read and a write to
// the same address are never issued together.  Read data returns one cycle
// after the grant.
//   clk, rst       : clock, asynchronous active-high reset
//   r0, r1         : requester buses (slave side)
//   mem_*          : memory read/write port drive, mem_data_out from memory
//   conflict_cnt   : saturating count of cycles with a deferred request
module data_memory_arbiter #(
    parameter int DW = 64,
    parameter int AW = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    data_memory_arbiter_if.slave r0,
    data_memory_arbiter_if.slave r1,
    output logic [DW-1:0]        mem_data_in,
    output logic [AW-1:0]        mem_read_adr,
    output logic [AW-1:0]        mem_write_adr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    input  logic [DW-1:0]        mem_data_out,
    output logic [15:0]          conflict_cnt
);

    function automatic logic pick(input logic [1:0] cand, input logic p);
        if (cand == 2'b11) return p;
        return cand[1];
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [1:0]    req, we, gnt, rd_cand, wr_cand;
    logic [AW-1:0] adr [2];
    logic [DW-1:0] wdata [2];

    logic          prio, hold, hold_id, rd_pend, rd_id;
    logic [DW-1:0] rdata0, rdata1;

    logic          rd_any, wr_any, rd_win, wr_win;
    logic          hazard, held_turn, rd_gnt, wr_gnt;
    logic          hold_nxt, hold_id_nxt;

    assign req      = {r1.req, r0.req};
    assign we       = {r1.we, r0.we};
    assign adr[0]   = r0.adr;
    assign adr[1]   = r1.adr;
    assign wdata[0] = r0.wdata;
    assign wdata[1] = r1.wdata;

    assign rd_cand = req & ~we;
    assign wr_cand = req & we;
    assign rd_any  = |rd_cand;
    assign wr_any  = |wr_cand;
    assign rd_win  = pick(rd_cand, prio);
    assign wr_win  = pick(wr_cand, prio);

    // A requester is either a reader or a writer, so when both slots are
    // occupied the winners are always different requesters.
    assign hazard    = rd_any && wr_any && (rd_win != wr_win) && (adr[rd_win] == adr[wr_win]);
    // The deferred reader gets its turn on the next collision.
    assign held_turn = hold && (hold_id == rd_win);
    assign rd_gnt    = rd_any && !(hazard && !held_turn);
    assign wr_gnt    = wr_any && !(hazard && held_turn);

    always_comb begin
        gnt = 2'b00;
        if (rd_gnt) gnt[rd_win] = 1'b1;
        if (wr_gnt) gnt[wr_win] = 1'b1;
    end

    assign r0.gnt = gnt[0];
    assign r1.gnt = gnt[1];

    assign mem_rd        = rd_gnt;
    assign mem_read_adr  = rd_gnt ? adr[rd_win] : '0;
    assign mem_wr        = wr_gnt;
    assign mem_write_adr = wr_gnt ? adr[wr_win] : '0;
    assign mem_data_in   = wr_gnt ? wdata[wr_win] : '0;

    always_comb begin
        hold_nxt    = hold;
        hold_id_nxt = hold_id;
        if (hazard && !held_turn) begin
            hold_nxt    = 1'b1;
            hold_id_nxt = rd_win;
        end else if (hold && ((rd_gnt && rd_win == hold_id) || !rd_cand[hold_id])) begin
            // Served, or the held requester abandoned its read.
            hold_nxt = 1'b0;
        end
    end

    // Grant edge: arbitration state, counter and read return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio         <= 1'b0;
            hold         <= 1'b0;
            hold_id      <= 1'b0;
            rd_pend      <= 1'b0;
            rd_id        <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
            conflict_cnt <= '0;
        end else begin
            if (gnt[prio]) prio <= ~prio;
            hold    <= hold_nxt;
            hold_id <= hold_id_nxt;
            rd_pend <= rd_gnt;
            rd_id   <= rd_win;
            if (rd_gnt && !rd_win) rdata0 <= mem_data_out;
            if (rd_gnt && rd_win)  rdata1 <= mem_data_out;
            if (|(req & ~gnt)) conflict_cnt <= sat_inc(conflict_cnt);
        end
    end

    assign r0.rvalid = rd_pend && !rd_id;
    assign r1.rvalid = rd_pend && rd_id;
    assign r0.rdata  = rdata0;
    assign r1.rdata  = rdata1;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: behavioural memory, shadow-memory
// scoreboard, directed scenarios, randomized traffic and counter saturation.
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] mem_data_in, mem_data_out;
    logic [9:0]  mem_read_adr, mem_write_adr;
    logic        mem_rd, mem_wr;
    logic [15:0] conflict_cnt;

    data_memory_arbiter_if #(.DW(64), .AW(10)) rq0 ();
    data_memory_arbiter_if #(.DW(64), .AW(10)) rq1 ();

    data_memory_arbiter #(.DW(64), .AW(10)) dut (
        .clk(clk), .rst(rst), .r0(rq0), .r1(rq1),
        .mem_data_in(mem_data_in), .mem_read_adr(mem_read_adr),
        .mem_write_adr(mem_write_adr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_data_out(mem_data_out), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Memory: write at the edge, combinational read
    logic [63:0] mem [1024];
    always @(posedge clk) if (mem_wr) mem[mem_write_adr] <= mem_data_in;
    assign mem_data_out = mem[mem_read_adr];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: shadow memory in grant order, expected read returns,
    // and the deferred-request counter
    typedef struct { bit id; logic [63:0] d; bit known; } exp_t;
    exp_t        q[$];
    logic [63:0] shadow [1024];
    bit          known [1024];
    logic [15:0] cnt_model = 16'd0;
    int          wait_c [2];

    always @(negedge clk) begin
        logic [1:0]  req_v, we_v, gnt_v, rv_v, rv_exp, rc, wc;
        logic [9:0]  a [2];
        logic [63:0] wd [2];
        logic [63:0] rdv [2];
        exp_t        e;
        int          nrd, nwr;
        bit          hz;
        req_v = {rq1.req, rq0.req};
        we_v  = {rq1.we, rq0.we};
        gnt_v = {rq1.gnt, rq0.gnt};
        rv_v  = {rq1.rvalid, rq0.rvalid};
        a[0] = rq0.adr;    a[1] = rq1.adr;
        wd[0] = rq0.wdata; wd[1] = rq1.wdata;
        rdv[0] = rq0.rdata; rdv[1] = rq1.rdata;
        if (rst) begin
            q.delete();
            cnt_model = 16'd0;
            wait_c[0] = 0;
            wait_c[1] = 0;
        end else begin
            rv_exp = (q.size() > 0) ? (q[0].id ? 2'b10 : 2'b01) : 2'b00;
            check("rvalid", 64'(rv_v), 64'(rv_exp));
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.known) check("rdata", rdv[e.id], e.d);
            end
            check("conflict_cnt", 64'(conflict_cnt), 64'(cnt_model));
            check("gnt_without_req", 64'(gnt_v & ~req_v), 64'd0);
            nrd = 0;
            nwr = 0;
            for (int k = 0; k < 2; k++) begin
                if (gnt_v[k] && req_v[k]) begin
                    if (we_v[k]) begin
                        nwr++;
                        check("mem_write_adr", 64'(mem_write_adr), 64'(a[k]));
                        check("mem_data_in", mem_data_in, wd[k]);
                    end else begin
                        nrd++;
                        check("mem_read_adr", 64'(mem_read_adr), 64'(a[k]));
                    end
                end
            end
            check("mem_rd", 64'(mem_rd), 64'(nrd == 1));
            check("mem_wr", 64'(mem_wr), 64'(nwr == 1));
            if (mem_rd && mem_wr) check("rw_same_adr", 64'(mem_read_adr == mem_write_adr), 64'd0);
            rc = req_v & ~we_v;
            wc = req_v & we_v;
            hz = (rc != 2'b00) && (wc != 2'b00) && (a[rc[1]] == a[wc[1]]);
            if (hz) begin
                check("hazard_one_slot", 64'(int'(mem_rd) + int'(mem_wr)), 64'd1);
            end else begin
                check("rd_slot_used", 64'(mem_rd), 64'(rc != 2'b00));
                check("wr_slot_used", 64'(mem_wr), 64'(wc != 2'b00));
            end
            for (int k = 0; k < 2; k++) begin
                if (req_v[k] && !gnt_v[k]) begin
                    wait_c[k]++;
                    check("starvation", 64'(wait_c[k] > 6), 64'd0);
                end else begin
                    wait_c[k] = 0;
                end
            end
            for (int k = 0; k < 2; k++)
                if (gnt_v[k] && req_v[k] && !we_v[k])
                    q.push_back('{id: 1'(k), d: shadow[a[k]], known: known[a[k]]});
            for (int k = 0; k < 2; k++)
                if (gnt_v[k] && req_v[k] && we_v[k]) begin
                    shadow[a[k]] = wd[k];
                    known[a[k]]  = 1'b1;
                end
            if (|(req_v & ~gnt_v) && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic r, input logic w,
                           input logic [9:0] a, input logic [63:0] d);
        if (k == 0) begin
            rq0.req = r; rq0.we = w; rq0.adr = a; rq0.wdata = d;
        end else begin
            rq1.req = r; rq1.we = w; rq1.adr = a; rq1.wdata = d;
        end
    endtask

    task automatic chk_gnt(input string name, input logic [1:0] exp);
        #1;
        check(name, 64'({rq1.gnt, rq0.gnt}), 64'(exp));
    endtask

    initial begin
        logic [1:0] g;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        step();
        step();
        check("reset_rvalid", 64'({rq1.rvalid, rq0.rvalid}), 64'd0);
        check("reset_cnt", 64'(conflict_cnt), 64'd0);
        rst = 1'b0;

        // Read contention from reset: r0 first, then r1
        set_req(0, 1, 0, 10'd1, 0);
        set_req(1, 1, 0, 10'd2, 0);
        chk_gnt("rc_cycle0_gnt", 2'b01);
        step();
        set_req(0, 0, 0, 0, 0);
        chk_gnt("rc_cycle1_gnt", 2'b10);
        step();
        set_req(1, 0, 0, 0, 0);
        check("rc_conflict_cnt", 64'(conflict_cnt), 64'd1);

        // Preload 7, then parallel write 5 / read 7
        set_req(0, 1, 1, 10'd7, 64'hAA);
        chk_gnt("preload_gnt", 2'b01);
        step();
        set_req(0, 1, 1, 10'd5, 64'h0123456789ABCDEF);
        set_req(1, 1, 0, 10'd7, 0);
        chk_gnt("par_gnt", 2'b11);
        check("par_mem_rd_wr", 64'({mem_rd, mem_wr}), 64'd3);
        step();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 1, 0, 10'd5, 0);
        check("par_rvalid", 64'(rq1.rvalid), 64'd1);
        check("par_rdata", rq1.rdata, 64'hAA);
        step();
        set_req(1, 0, 0, 0, 0);
        check("par_readback", rq1.rdata, 64'h0123456789ABCDEF);

        // Address hazard: r0 writes 9, r1 reads 9 continuously
        set_req(0, 1, 1, 10'd9, 64'h9999);
        set_req(1, 1, 0, 10'd9, 0);
        chk_gnt("hz_cycle0_gnt", 2'b01);
        check("hz_cycle0_mem", 64'({mem_rd, mem_wr}), 64'd1);
        step();
        set_req(0, 1, 1, 10'd9, 64'h1111);
        chk_gnt("hz_cycle1_gnt", 2'b10);
        check("hz_cycle1_mem", 64'({mem_rd, mem_wr}), 64'd2);
        step();
        set_req(1, 0, 0, 0, 0);
        check("hz_rdata", rq1.rdata, 64'h9999);
        chk_gnt("hz_cycle2_gnt", 2'b01);
        step();
        set_req(0, 0, 0, 0, 0);

        // Write contention with prio = 1: r1 first, r0 last
        set_req(0, 1, 1, 10'd3, 64'd1);
        set_req(1, 1, 1, 10'd3, 64'd2);
        chk_gnt("wc_cycle0_gnt", 2'b10);
        step();
        set_req(1, 0, 0, 0, 0);
        chk_gnt("wc_cycle1_gnt", 2'b01);
        step();
        set_req(0, 1, 0, 10'd3, 0);
        step();
        set_req(0, 0, 0, 0, 0);
        check("wc_final", rq0.rdata, 64'd1);

        // Reset during a read return
        set_req(0, 1, 0, 10'd5, 0);
        step();
        set_req(0, 0, 0, 0, 0);
        check("pre_reset_rvalid", 64'(rq0.rvalid), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rvalid", 64'({rq1.rvalid, rq0.rvalid}), 64'd0);
        check("async_rdata0", rq0.rdata, 64'd0);
        check("async_rdata1", rq1.rdata, 64'd0);
        check("async_cnt", 64'(conflict_cnt), 64'd0);
        step();
        step();
        rst = 1'b0;
        set_req(0, 1, 0, 10'd1, 0);
        set_req(1, 1, 0, 10'd2, 0);
        chk_gnt("post_reset_prio", 2'b01);
        step();
        set_req(0, 0, 0, 0, 0);
        step();
        set_req(1, 0, 0, 0, 0);
        step();

        // Randomized traffic over a small address window
        g = 2'b00;
        repeat (2000) begin
            for (int k = 0; k < 2; k++) begin
                if (!(k == 0 ? rq0.req : rq1.req) || g[k]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(k, 0, 0, 0, 0);
                    else
                        set_req(k, 1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)),
                                {$urandom, $urandom});
                end
            end
            #2;
            g = {rq1.gnt, rq0.gnt};
            step();
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        repeat (3) step();

        // Counter saturation: continuous read contention
        set_req(0, 1, 0, 10'd1, 0);
        set_req(1, 1, 0, 10'd2, 0);
        repeat (66000) step();
        check("cnt_saturated", 64'(conflict_cnt), 64'hFFFF);
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
